// File: rtl/route_pkg.sv
// Shared constants and helpers for the route stage: word layout, hold-buffer
// depth and the destination-to-strobe decode.
package route_pkg;

  localparam int DATA_W     = 6;
  localparam int SKID_DEPTH = 4;
  localparam int DEST_W     = 2;
  localparam int DEST_MSB   = DATA_W - 1;
  localparam int DEST_LSB   = DATA_W - DEST_W;
  localparam int NUM_OUT    = 4;

  typedef logic [DEST_W-1:0] dest_t;

  function automatic logic [NUM_OUT-1:0] dest_onehot(input dest_t dest);
    logic [NUM_OUT-1:0] v;
    case (dest)
      2'd0:    v = 4'b0001;
      2'd1:    v = 4'b0010;
      2'd2:    v = 4'b0100;
      2'd3:    v = 4'b1000;
      default: v = 4'b0000;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/route_stage_if.sv
// Arbiter-side inputs, input FIFO data, output FIFO backpressure and the
// registered outputs of the route stage, bundled as one interface.
interface route_stage_if #(
  parameter int DATA_W = route_pkg::DATA_W
);

  logic              pop_F0, pop_F1, pop_F2, pop_F3;
  logic [1:0]        select;
  logic [DATA_W-1:0] data_in_P0, data_in_P1, data_in_P2, data_in_P3;
  logic              almost_full_P4, almost_full_P5, almost_full_P6, almost_full_P7;
  logic [DATA_W-1:0] data_out;
  logic              push_P4, push_P5, push_P6, push_P7;
  logic              stall;
  logic              err_overflow;

  modport master (
    output pop_F0, pop_F1, pop_F2, pop_F3, select,
    output data_in_P0, data_in_P1, data_in_P2, data_in_P3,
    output almost_full_P4, almost_full_P5, almost_full_P6, almost_full_P7,
    input  data_out, push_P4, push_P5, push_P6, push_P7, stall, err_overflow
  );

  modport slave (
    input  pop_F0, pop_F1, pop_F2, pop_F3, select,
    input  data_in_P0, data_in_P1, data_in_P2, data_in_P3,
    input  almost_full_P4, almost_full_P5, almost_full_P6, almost_full_P7,
    output data_out, push_P4, push_P5, push_P6, push_P7, stall, err_overflow
  );

endinterface

// File: rtl/route_stage_skid_fifo.sv
// Hold buffer for words whose destination is backpressured. DEPTH must be a
// power of two so the pointers wrap naturally.
module skid_fifo #(
  parameter int DATA_W = 6,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset_L,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [DATA_W-1:0]        i_data,
  output logic [DATA_W-1:0]        o_data,
  output logic                     o_empty,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_wr;
  logic              w_rd;

  assign o_empty = (r_count == {CNT_W{1'b0}});
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];

  // A full buffer still accepts a write when the head leaves in the same cycle.
  assign w_rd = i_pop && !o_empty;
  assign w_wr = i_push && (!o_full || w_rd);

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= {DATA_W{1'b0}};
    end else if (w_wr) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

endmodule

// File: rtl/route_stage.sv
// Routes words popped from four input FIFOs to four output FIFOs by the
// destination field, parking backpressured words in an in-order hold buffer.
module route_stage #(
  parameter int DATA_W     = route_pkg::DATA_W,
  parameter int SKID_DEPTH = route_pkg::SKID_DEPTH
) (
  input  logic          clk,
  input  logic          reset_L,
  route_stage_if.slave  bus
);

  import route_pkg::*;

  localparam int CNT_W = $clog2(SKID_DEPTH) + 1;

  logic              r_in_valid;
  logic [1:0]        r_sel_d;
  logic [DATA_W-1:0] r_data_out;
  logic [3:0]        r_push;
  logic              r_stall;
  logic              r_err;

  logic              w_pop_any;
  logic [3:0]        w_af;
  logic [DATA_W-1:0] w_word;
  logic [DATA_W-1:0] w_head;
  logic [DATA_W-1:0] w_issue_word;
  dest_t             w_word_dest;
  dest_t             w_head_dest;
  dest_t             w_issue_dest;
  logic              w_issue;
  logic              w_fifo_push;
  logic              w_fifo_pop;
  logic              w_drop;
  logic              w_empty;
  logic              w_full;
  logic [CNT_W-1:0]  w_count;
  logic [CNT_W-1:0]  w_count_next;

  assign w_pop_any = bus.pop_F0 | bus.pop_F1 | bus.pop_F2 | bus.pop_F3;
  assign w_af      = {bus.almost_full_P7, bus.almost_full_P6,
                      bus.almost_full_P5, bus.almost_full_P4};

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_in_valid <= 1'b0;
      r_sel_d    <= 2'd0;
    end else begin
      r_in_valid <= w_pop_any;
      if (w_pop_any) r_sel_d <= bus.select;
    end
  end

  always_comb begin
    w_word = {DATA_W{1'b0}};
    case (r_sel_d)
      2'd0:    w_word = bus.data_in_P0;
      2'd1:    w_word = bus.data_in_P1;
      2'd2:    w_word = bus.data_in_P2;
      2'd3:    w_word = bus.data_in_P3;
      default: w_word = {DATA_W{1'b0}};
    endcase
  end

  assign w_word_dest  = w_word[DEST_MSB:DEST_LSB];
  assign w_head_dest  = w_head[DEST_MSB:DEST_LSB];
  assign w_issue_dest = w_issue_word[DEST_MSB:DEST_LSB];

  // Buffered words always go first; a blocked head stalls everything behind it.
  always_comb begin
    w_issue      = 1'b0;
    w_issue_word = w_word;
    w_fifo_push  = 1'b0;
    w_fifo_pop   = 1'b0;
    w_drop       = 1'b0;
    if (!w_empty) begin
      w_issue_word = w_head;
      if (!w_af[w_head_dest]) begin
        w_fifo_pop = 1'b1;
        w_issue    = 1'b1;
      end else begin
        w_fifo_pop = 1'b0;
        w_issue    = 1'b0;
      end
      if (r_in_valid) begin
        if (!w_full || w_fifo_pop) begin
          w_fifo_push = 1'b1;
        end else begin
          w_drop = 1'b1;
        end
      end else begin
        w_fifo_push = 1'b0;
      end
    end else if (r_in_valid) begin
      if (!w_af[w_word_dest]) begin
        w_issue = 1'b1;
      end else begin
        w_fifo_push = 1'b1;
      end
    end else begin
      w_issue = 1'b0;
    end
  end

  always_comb begin
    w_count_next = w_count;
    case ({w_fifo_push, w_fifo_pop})
      2'b10:   w_count_next = w_count + CNT_W'(1);
      2'b01:   w_count_next = w_count - CNT_W'(1);
      default: w_count_next = w_count;
    endcase
  end

  skid_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (SKID_DEPTH)
  ) u_skid (
    .clk     (clk),
    .reset_L (reset_L),
    .i_push  (w_fifo_push),
    .i_pop   (w_fifo_pop),
    .i_data  (w_word),
    .o_data  (w_head),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_count (w_count)
  );

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_data_out <= {DATA_W{1'b0}};
      r_push     <= 4'b0000;
      r_stall    <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      if (w_issue) r_data_out <= w_issue_word;
      r_push  <= w_issue ? dest_onehot(w_issue_dest) : 4'b0000;
      r_stall <= (w_count_next != {CNT_W{1'b0}});
      r_err   <= r_err | w_drop;
    end
  end

  assign bus.data_out     = r_data_out;
  assign bus.push_P4      = r_push[0];
  assign bus.push_P5      = r_push[1];
  assign bus.push_P6      = r_push[2];
  assign bus.push_P7      = r_push[3];
  assign bus.stall        = r_stall;
  assign bus.err_overflow = r_err;

endmodule

// File: tb/tb_route_stage.sv
// Self-checking bench for route_stage: directed vector table, corner-case
// sequences and a random run, all checked against a cycle model and scoreboard.
module tb_route_stage;

  logic clk;
  logic reset_L;
  int   n_checks;
  int   n_fail;

  route_stage_if #(.DATA_W(6)) bus ();

  route_stage #(.DATA_W(6), .SKID_DEPTH(4)) dut (
    .clk     (clk),
    .reset_L (reset_L),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       pop;
    logic [1:0] sel;
    logic [5:0] din;
    logic [3:0] af;
    logic [3:0] exp_push;
    logic [5:0] exp_data;
    logic       exp_stall;
  } vec_t;

  vec_t       tbl [12];
  logic [5:0] m_q [$];
  logic [5:0] exp_q [$];
  logic       m_in_valid;
  logic [1:0] m_sel;
  logic [5:0] m_data;
  logic [3:0] m_push;
  logic       m_stall;
  logic       m_err;

  function automatic logic [3:0] push_vec();
    return {bus.push_P7, bus.push_P6, bus.push_P5, bus.push_P4};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    exp_q.delete();
    m_in_valid = 1'b0;
    m_sel      = 2'd0;
    m_data     = 6'd0;
    m_push     = 4'd0;
    m_stall    = 1'b0;
    m_err      = 1'b0;
  endtask

  // One clock edge of the intended behaviour, evaluated from the inputs being driven.
  task automatic model_eval(input logic pop, input logic [1:0] sel, input logic [5:0] w,
                            input logic [3:0] af);
    logic       iss;
    logic [5:0] iw;
    iss = 1'b0;
    iw  = 6'd0;
    if (m_q.size() != 0) begin
      if (!af[m_q[0][5:4]]) begin
        iss = 1'b1;
        iw  = m_q.pop_front();
      end
      if (m_in_valid) begin
        if (m_q.size() < 4) m_q.push_back(w);
        else m_err = 1'b1;
      end
    end else if (m_in_valid) begin
      if (!af[w[5:4]]) begin
        iss = 1'b1;
        iw  = w;
      end else begin
        m_q.push_back(w);
      end
    end
    m_push = 4'd0;
    if (iss) begin
      m_push = 4'b0001 << iw[5:4];
      m_data = iw;
      exp_q.push_back(iw);
    end
    m_stall    = (m_q.size() != 0);
    m_in_valid = pop;
    if (pop) m_sel = sel;
  endtask

  task automatic check_outputs();
    logic [3:0] p;
    p = push_vec();
    chk("push", {28'd0, p}, {28'd0, m_push});
    chk("data_out", {26'd0, bus.data_out}, {26'd0, m_data});
    chk("stall", {31'd0, bus.stall}, {31'd0, m_stall});
    chk("err_overflow", {31'd0, bus.err_overflow}, {31'd0, m_err});
    chk("push_onehot", $countones(p), (p != 4'd0) ? 32'd1 : 32'd0);
    if (p != 4'd0) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected: got push 0x%0h data 0x%0h, expected no push at %0t",
                 p, bus.data_out, $time);
      end else begin
        chk("sb_order", {26'd0, bus.data_out}, {26'd0, exp_q.pop_front()});
      end
    end
  endtask

  // Entered and left at a falling edge; the selected port carries din, the others its inverse.
  task automatic cycle(input logic pop, input logic [1:0] sel, input logic [5:0] din,
                       input logic [3:0] af);
    bus.pop_F0 = pop && (sel == 2'd0);
    bus.pop_F1 = pop && (sel == 2'd1);
    bus.pop_F2 = pop && (sel == 2'd2);
    bus.pop_F3 = pop && (sel == 2'd3);
    bus.select = sel;
    bus.data_in_P0 = (m_sel == 2'd0) ? din : ~din;
    bus.data_in_P1 = (m_sel == 2'd1) ? din : ~din;
    bus.data_in_P2 = (m_sel == 2'd2) ? din : ~din;
    bus.data_in_P3 = (m_sel == 2'd3) ? din : ~din;
    {bus.almost_full_P7, bus.almost_full_P6, bus.almost_full_P5, bus.almost_full_P4} = af;
    model_eval(pop, sel, din, af);
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    int         npush;
    logic [3:0] af_r;
    n_checks = 0;
    n_fail   = 0;
    reset_L  = 1'b0;
    model_reset();
    cycle_inputs_idle();

    tbl[0]  = '{1'b1, 2'd2, 6'b000000, 4'b0000, 4'b0000, 6'b000000, 1'b0};
    tbl[1]  = '{1'b0, 2'd2, 6'b100101, 4'b0000, 4'b0100, 6'b100101, 1'b0};
    tbl[2]  = '{1'b0, 2'd0, 6'b000000, 4'b0000, 4'b0000, 6'b100101, 1'b0};
    tbl[3]  = '{1'b1, 2'd1, 6'b000000, 4'b0010, 4'b0000, 6'b100101, 1'b0};
    tbl[4]  = '{1'b0, 2'd1, 6'b010011, 4'b0010, 4'b0000, 6'b100101, 1'b1};
    tbl[5]  = '{1'b0, 2'd1, 6'b000000, 4'b0010, 4'b0000, 6'b100101, 1'b1};
    tbl[6]  = '{1'b0, 2'd1, 6'b000000, 4'b0000, 4'b0010, 6'b010011, 1'b0};
    tbl[7]  = '{1'b0, 2'd1, 6'b000000, 4'b0000, 4'b0000, 6'b010011, 1'b0};
    tbl[8]  = '{1'b1, 2'd0, 6'b000000, 4'b0000, 4'b0000, 6'b010011, 1'b0};
    tbl[9]  = '{1'b1, 2'd3, 6'b001110, 4'b0000, 4'b0001, 6'b001110, 1'b0};
    tbl[10] = '{1'b0, 2'd3, 6'b110001, 4'b0000, 4'b1000, 6'b110001, 1'b0};
    tbl[11] = '{1'b0, 2'd0, 6'b000000, 4'b0000, 4'b0000, 6'b110001, 1'b0};

    repeat (2) @(negedge clk);
    chk("reset_push", {28'd0, push_vec()}, 32'd0);
    chk("reset_data", {26'd0, bus.data_out}, 32'd0);
    chk("reset_stall", {31'd0, bus.stall}, 32'd0);
    chk("reset_err", {31'd0, bus.err_overflow}, 32'd0);
    reset_L = 1'b1;

    for (int i = 0; i < 12; i++) begin
      cycle(tbl[i].pop, tbl[i].sel, tbl[i].din, tbl[i].af);
      chk($sformatf("tbl%0d_push", i), {28'd0, push_vec()}, {28'd0, tbl[i].exp_push});
      chk($sformatf("tbl%0d_data", i), {26'd0, bus.data_out}, {26'd0, tbl[i].exp_data});
      chk($sformatf("tbl%0d_stall", i), {31'd0, bus.stall}, {31'd0, tbl[i].exp_stall});
    end

    // A word for a free port must wait behind a blocked head.
    cycle(1'b1, 2'd0, 6'd0, 4'b0001);
    cycle(1'b1, 2'd3, 6'b000111, 4'b0001);
    cycle(1'b0, 2'd0, 6'b111000, 4'b0001);
    chk("no_bypass_a", {28'd0, push_vec()}, 32'd0);
    cycle(1'b0, 2'd0, 6'd0, 4'b0001);
    chk("no_bypass_b", {28'd0, push_vec()}, 32'd0);
    cycle(1'b0, 2'd0, 6'd0, 4'b0000);
    chk("order_first", {28'd0, push_vec()}, 32'h1);
    cycle(1'b0, 2'd0, 6'd0, 4'b0000);
    chk("order_second", {28'd0, push_vec()}, 32'h8);
    chk("order_second_data", {26'd0, bus.data_out}, 32'h38);

    cycle(1'b1, 2'd0, 6'd0, 4'b0001);
    for (int k = 0; k < 5; k++) cycle(k < 4, 2'd0, {2'b00, 4'(k + 1)}, 4'b0001);
    chk("ovf_err_set", {31'd0, bus.err_overflow}, 32'd1);
    chk("ovf_stall", {31'd0, bus.stall}, 32'd1);
    npush = 0;
    for (int k = 0; k < 6; k++) begin
      cycle(1'b0, 2'd0, 6'd0, 4'b0000);
      if (push_vec() != 4'd0) npush++;
    end
    chk("ovf_drained", npush, 32'd4);
    chk("ovf_err_sticky", {31'd0, bus.err_overflow}, 32'd1);
    chk("ovf_stall_clear", {31'd0, bus.stall}, 32'd0);

    // Asynchronous reset with three words parked and one in flight.
    cycle(1'b1, 2'd0, 6'd0, 4'b0001);
    cycle(1'b1, 2'd0, 6'h01, 4'b0001);
    cycle(1'b1, 2'd0, 6'h02, 4'b0001);
    cycle(1'b1, 2'd0, 6'h03, 4'b0001);
    chk("pre_rst_stall", {31'd0, bus.stall}, 32'd1);
    @(posedge clk);
    #2 reset_L = 1'b0;
    #1;
    chk("async_rst_push", {28'd0, push_vec()}, 32'd0);
    chk("async_rst_data", {26'd0, bus.data_out}, 32'd0);
    chk("async_rst_stall", {31'd0, bus.stall}, 32'd0);
    chk("async_rst_err", {31'd0, bus.err_overflow}, 32'd0);
    @(negedge clk);
    cycle_inputs_idle();
    model_reset();
    @(negedge clk);
    reset_L = 1'b1;
    npush = 0;
    for (int k = 0; k < 5; k++) begin
      cycle(1'b0, 2'd0, 6'd0, 4'b0000);
      if (push_vec() != 4'd0) npush++;
    end
    chk("post_rst_no_push", npush, 32'd0);
    cycle(1'b1, 2'd1, 6'd0, 4'b0000);
    chk("first_pop_lat1", {28'd0, push_vec()}, 32'd0);
    cycle(1'b0, 2'd0, 6'b011010, 4'b0000);
    chk("first_pop_lat2", {28'd0, push_vec()}, 32'h2);

    af_r = 4'b0000;
    for (int c = 0; c < 10000; c++) begin
      if ((c % 8) == 0) begin
        af_r = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
      end
      cycle($urandom_range(0, 9) < 7, 2'($urandom_range(0, 3)),
            6'($urandom_range(0, 63)), af_r);
    end
    for (int k = 0; k < 10; k++) cycle(1'b0, 2'd0, 6'd0, 4'b0000);
    chk("sb_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  task automatic cycle_inputs_idle();
    bus.pop_F0 = 1'b0;
    bus.pop_F1 = 1'b0;
    bus.pop_F2 = 1'b0;
    bus.pop_F3 = 1'b0;
    bus.select = 2'd0;
    bus.data_in_P0 = 6'd0;
    bus.data_in_P1 = 6'd0;
    bus.data_in_P2 = 6'd0;
    bus.data_in_P3 = 6'd0;
    bus.almost_full_P4 = 1'b0;
    bus.almost_full_P5 = 1'b0;
    bus.almost_full_P6 = 1'b0;
    bus.almost_full_P7 = 1'b0;
  endtask

endmodule

// File: doc/route_stage.md
ROUTE_STAGE -- requirements
Module: route_stage

Interface
REQ-001 Parameter DATA_W, default 6, SHALL set word width; word[DATA_W-1:DATA_W-2] is the 2-bit destination (0..3 -> P4..P7).
REQ-002 Parameter SKID_DEPTH, default 4, SHALL set hold-buffer entries; it must be a power of two and at least 4.
REQ-003 The design SHALL use one clock and an asynchronous, active-low reset, with ports named as follows.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 reset_L  in  1  asynchronous, active-low reset.
REQ-006 pop_F0..pop_F3  in  1 each  arbiter pops; at most one high per cycle.
REQ-007 select  in  2  arbiter source index, valid with the pops.
REQ-008 data_in_P0..data_in_P3  in  DATA_W each  input FIFO read data, valid one cycle after the matching pop.
REQ-009 almost_full_P4..almost_full_P7  in  1 each  output FIFO backpressure.
REQ-010 data_out  out  DATA_W  registered word to the output FIFOs.
REQ-011 push_P4..push_P7  out  1 each  registered one-hot write strobes.
REQ-012 stall  out  1  registered; tells the arbiter to stop popping.
REQ-013 err_overflow  out  1  sticky flag for a dropped word.

Function
REQ-014 Cycle t pop (any pop_Fx=1) SHALL register in_valid=1 and sel_d=select at edge t.
REQ-015 During cycle t+1, when in_valid=1, the incoming word SHALL be data_in_P[sel_d].
REQ-016 Fast path: hold buffer empty and almost_full of the word's destination low -> at edge t+1, data_out<=word and push_P(4+dest)<=1; pop-to-push latency is exactly 2 cycles.
REQ-017 Push outputs SHALL be one-hot or all-zero; with no word issued that cycle, all push outputs are 0 and data_out holds its value.
REQ-018 Destination almost_full high on arrival -> the word SHALL enter the hold buffer; it is never pushed while its destination is almost_full.
REQ-019 Hold buffer non-empty -> its head SHALL issue before any new word; a new word arriving that cycle enqueues behind it, preserving order.
REQ-020 Head and tail may change in the same cycle; occupancy is then unchanged.
REQ-021 Head blocked (its destination almost_full) -> nothing issues that cycle; there is no bypass by later words, even for other destinations.
REQ-022 At most one word SHALL issue per cycle.
REQ-023 A word arriving with the buffer full and no dequeue that cycle SHALL be dropped, and err_overflow<=1 until reset.
REQ-024 stall SHALL be registered as (buffer occupancy after the edge != 0).
REQ-025 Read/write pointers SHALL be log2(SKID_DEPTH) bits and wrap modulo SKID_DEPTH.
REQ-026 The occupancy counter SHALL be log2(SKID_DEPTH)+1 bits.

Reset
REQ-027 reset_L=0 SHALL immediately force data_out=0, all push outputs=0, stall=0, err_overflow=0, in_valid=0, sel_d=0, occupancy=0 and pointers=0.
REQ-028 Reset asserted mid-operation SHALL discard all buffered and in-flight words with no push.
REQ-029 After reset release, the first push SHALL occur no earlier than 2 cycles after the first pop.

Structure
REQ-030 A shared package route_pkg SHALL hold DATA_W, SKID_DEPTH, the destination field MSB/LSB positions, and a dest-to-one-hot function.
REQ-031 The hold buffer SHALL be a sub-module skid_fifo (push/pop/data/empty/full/count).
REQ-032 Output register, input mux and issue logic SHALL reside in route_stage.

Verification
REQ-033 Reset then pop_F2=1 with select=2 and data_in_P2=6'b10_0101, all almost_full low -> push_P6=1 and data_out=6'b10_0101 exactly 2 cycles after the pop; stall stays 0.
REQ-034 almost_full_P5=1, pop word 6'b01_0011 -> no push, stall=1 next cycle; drop almost_full_P5 -> push_P5=1 with 6'b01_0011 one cycle later, then stall=0.
REQ-035 almost_full_P4=1, words to P4 then P7 -> P7 word not issued until the P4 word has issued; order P4,P7 is kept.
REQ-036 almost_full_P4=1, 5 consecutive pops to P4 -> 4 buffered, 5th dropped, err_overflow=1 and it persists after almost_full_P4 drops and the 4 words drain.
REQ-037 3 words buffered, reset_L=0 asynchronously mid-cycle -> all outputs 0 immediately; no push after release.
REQ-038 Random pops over all destinations with random almost_full, 10k cycles -> scoreboard shows in-order, one-hot, no loss unless err_overflow=1.
